fwd_stall_ctrl: RTL and testbench

FWD_STALL_CTRL -- requirements
Module: fwd_stall_ctrl

---
 rtl/fwd_stall_ctrl_if.sv | 50 +++++
 rtl/fwd_stall_ctrl.sv | 126 ++++++++++++
 tb/tb_fwd_stall_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_stall_ctrl_if.sv
// Hazard-unit port bundle: pipeline state in,
// forward selects and stall/flush controls out.
interface fwd_stall_ctrl_if #(
  parameter int NSRC = 3,
  parameter int REGW = 4
);
  logic [NSRC*REGW-1:0] RA_D;
  logic [NSRC-1:0]      UseD;
  logic [NSRC*REGW-1:0] RA_E;
  logic [NSRC-1:0]      UseE;
  logic [REGW-1:0]      WA_E;
  logic [REGW-1:0]      WA_M;
  logic [REGW-1:0]      WA_W;
  logic                 RegWrE;
  logic                 RegWrM;
  logic                 RegWrW;
  logic                 MemtoRegE;
  logic                 BranchE;
  logic                 PCWrD;
  logic                 PCSrcW;
  logic                 MulStartE;
  logic [2*NSRC-1:0]    FwdE;
  logic                 StallF;
  logic                 StallD;
  logic                 StallE;
  logic                 FlushD;
  logic                 FlushE;
  logic                 FlushM;
  logic                 Busy;

  modport master (
    output RA_D, UseD, RA_E, UseE,
    output WA_E, WA_M, WA_W,
    output RegWrE, RegWrM, RegWrW,
    output MemtoRegE, BranchE,
    output PCWrD, PCSrcW, MulStartE,
    input  FwdE, StallF, StallD, StallE,
    input  FlushD, FlushE, FlushM, Busy
  );

  modport slave (
    input  RA_D, UseD, RA_E, UseE,
    input  WA_E, WA_M, WA_W,
    input  RegWrE, RegWrM, RegWrW,
    input  MemtoRegE, BranchE,
    input  PCWrD, PCSrcW, MulStartE,
    output FwdE, StallF, StallD, StallE,
    output FlushD, FlushE, FlushM, Busy
  );
endinterface

// File: rtl/fwd_stall_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use
// and multicycle stalls, PC-write wait and flushes.
module fwd_stall_ctrl #(
  parameter int NSRC      = 3,
  parameter int REGW      = 4,
  parameter int MUL_LAT   = 3,
  parameter int NOFWD_REG = 15
) (
  input  logic              clk,
  input  logic              reset,
  fwd_stall_ctrl_if.slave   bus
);

  localparam int CW =
    (MUL_LAT < 4) ? 2 : $clog2(MUL_LAT) + 1;
  localparam logic [CW-1:0] MUL_LOAD =
    CW'(MUL_LAT - 1);
  localparam logic [REGW-1:0] NOFWD =
    REGW'(NOFWD_REG);
  localparam logic MUL_MULTI = (MUL_LAT > 1);

  typedef enum logic {
    IDLE,
    PCWAIT
  } pc_state_e;

  pc_state_e       state_q;
  pc_state_e       state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  logic [2*NSRC-1:0] fwd_e;
  logic              ldr_stall;
  logic              mul_stall;
  logic              pc_pend;

  always_comb begin
    logic [REGW-1:0] ra;
    logic            m_hit;
    logic            w_hit;
    fwd_e = '0;
    ra    = '0;
    m_hit = 1'b0;
    w_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      ra    = bus.RA_E[i*REGW +: REGW];
      m_hit = bus.UseE[i] && bus.RegWrM &&
              (ra == bus.WA_M) && (ra != NOFWD);
      w_hit = bus.UseE[i] && bus.RegWrW &&
              (ra == bus.WA_W) && (ra != NOFWD);
      // M holds the younger result, so it wins
      if (m_hit)
        fwd_e[2*i +: 2] = 2'b10;
      else if (w_hit)
        fwd_e[2*i +: 2] = 2'b01;
      else
        fwd_e[2*i +: 2] = 2'b00;
    end
  end

  always_comb begin
    ldr_stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.UseD[i] &&
          (bus.RA_D[i*REGW +: REGW] == bus.WA_E))
        ldr_stall = 1'b1;
    end
    ldr_stall = ldr_stall &
                bus.RegWrE & bus.MemtoRegE;
  end

  always_comb begin
    mul_stall =
      ((cnt_q == '0) & bus.MulStartE & MUL_MULTI) |
      (cnt_q > CW'(1));
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
    else if (bus.MulStartE)
      cnt_d = MUL_LOAD;
  end

  assign pc_pend = (state_q == PCWAIT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.PCWrD && !bus.BranchE &&
            !(ldr_stall | mul_stall))
          state_d = PCWAIT;
      end
      PCWAIT: begin
        if (bus.PCSrcW)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.FwdE   = fwd_e;
  assign bus.StallE = mul_stall;
  assign bus.FlushM = mul_stall;
  assign bus.Busy   = mul_stall;
  assign bus.StallD = ldr_stall | mul_stall;
  assign bus.StallF = ldr_stall | mul_stall |
                      pc_pend;
  assign bus.FlushE = (ldr_stall | bus.BranchE) &
                      ~mul_stall;
  assign bus.FlushD = pc_pend | bus.PCSrcW |
                      bus.BranchE;

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Directed-vector bench for fwd_stall_ctrl with
// hand-computed expectations.
module tb_fwd_stall_ctrl;

  localparam int NSRC = 3;
  localparam int REGW = 4;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  fwd_stall_ctrl_if #(
    .NSRC(NSRC),
    .REGW(REGW)
  ) bus ();

  fwd_stall_ctrl #(
    .NSRC(NSRC),
    .REGW(REGW),
    .MUL_LAT(3),
    .NOFWD_REG(15)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.BranchE && bus.MulStartE)
      $display("note: illegal BranchE+MulStartE at %0t",
               $time);
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic clr();
    bus.RA_D      = '0;
    bus.UseD      = '0;
    bus.RA_E      = '0;
    bus.UseE      = '0;
    bus.WA_E      = '0;
    bus.WA_M      = '0;
    bus.WA_W      = '0;
    bus.RegWrE    = 1'b0;
    bus.RegWrM    = 1'b0;
    bus.RegWrW    = 1'b0;
    bus.MemtoRegE = 1'b0;
    bus.BranchE   = 1'b0;
    bus.PCWrD     = 1'b0;
    bus.PCSrcW    = 1'b0;
    bus.MulStartE = 1'b0;
  endtask

  // advance one edge; inputs are changed at +1
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle
  task automatic settle();
    #1;
  endtask

  function automatic logic [6:0] ctl();
    return {bus.StallF, bus.StallD, bus.StallE,
            bus.FlushD, bus.FlushE, bus.FlushM,
            bus.Busy};
  endfunction

  initial begin
    nvec  = 0;
    nerr  = 0;
    reset = 1'b1;
    clr();
    tick();
    tick();
    reset = 1'b0;
    settle();
    check("rst_fwd", 32'(bus.FwdE), 0);
    check("rst_ctl", 32'(ctl()), 0);
    check("rst_cnt", 32'(u_dut.cnt_q), 0);

    // forwarding
    bus.RA_E   = {4'd0, 4'd0, 4'd3};
    bus.UseE   = 3'b001;
    bus.WA_M   = 4'd3;
    bus.RegWrM = 1'b1;
    bus.WA_W   = 4'd3;
    bus.RegWrW = 1'b1;
    settle();
    check("fwd_m", 32'(bus.FwdE), 32'h02);
    bus.RegWrM = 1'b0;
    settle();
    check("fwd_w", 32'(bus.FwdE), 32'h01);
    bus.RA_E   = {4'd0, 4'd0, 4'd15};
    bus.WA_M   = 4'd15;
    bus.WA_W   = 4'd15;
    bus.RegWrM = 1'b1;
    settle();
    check("fwd_pc", 32'(bus.FwdE), 32'h00);
    bus.RA_E = {4'd0, 4'd7, 4'd0};
    bus.UseE = 3'b010;
    bus.WA_W = 4'd7;
    bus.WA_M = 4'd2;
    settle();
    check("fwd_op1", 32'(bus.FwdE), 32'h04);
    bus.UseE = 3'b000;
    settle();
    check("fwd_nouse", 32'(bus.FwdE), 32'h00);
    bus.RA_E = {4'd9, 4'd0, 4'd6};
    bus.UseE = 3'b101;
    bus.WA_M = 4'd9;
    bus.WA_W = 4'd6;
    settle();
    check("fwd_two", 32'(bus.FwdE), 32'h21);
    clr();

    // load-use: {StallF,D,E,FlushD,E,M,Busy}
    bus.WA_E      = 4'd5;
    bus.MemtoRegE = 1'b1;
    bus.RegWrE    = 1'b1;
    bus.RA_D      = {4'd5, 4'd0, 4'd0};
    bus.UseD      = 3'b100;
    settle();
    check("ldr_ctl", 32'(ctl()), 32'b1100100);
    bus.UseD = 3'b000;
    settle();
    check("ldr_nouse", 32'(ctl()), 0);
    bus.UseD      = 3'b100;
    bus.MemtoRegE = 1'b0;
    settle();
    check("ldr_noload", 32'(ctl()), 0);
    clr();

    // multicycle, MUL_LAT=3
    bus.MulStartE = 1'b1;
    settle();
    check("mul_c0", 32'(ctl()), 32'b1110011);
    check("mul_cnt0", 32'(u_dut.cnt_q), 0);
    tick();
    check("mul_c1", 32'(ctl()), 32'b1110011);
    check("mul_cnt1", 32'(u_dut.cnt_q), 2);
    tick();
    check("mul_c2", 32'(ctl()), 0);
    check("mul_cnt2", 32'(u_dut.cnt_q), 1);
    tick();
    bus.MulStartE = 1'b0;
    settle();
    check("mul_c3", 32'(ctl()), 0);
    check("mul_cnt3", 32'(u_dut.cnt_q), 0);

    // multicycle beats load-use
    bus.WA_E      = 4'd5;
    bus.MemtoRegE = 1'b1;
    bus.RegWrE    = 1'b1;
    bus.RA_D      = {4'd0, 4'd5, 4'd0};
    bus.UseD      = 3'b010;
    bus.MulStartE = 1'b1;
    settle();
    check("mx_flushe", 32'(bus.FlushE), 0);
    check("mx_stalld", 32'(bus.StallD), 1);
    check("mx_stalle", 32'(bus.StallE), 1);
    tick();
    clr();
    settle();
    check("mx_cnt2", 32'(bus.Busy), 1);
    tick();
    tick();
    check("mx_done", 32'(u_dut.cnt_q), 0);

    // taken branch
    bus.BranchE = 1'b1;
    settle();
    check("br_ctl", 32'(ctl()), 32'b0001100);
    tick();
    clr();
    settle();
    check("br_nostate", 32'(ctl()), 0);

    // PC write through regfile
    bus.PCWrD = 1'b1;
    settle();
    check("pc_c0", 32'(bus.StallF), 0);
    tick();
    bus.PCWrD = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      settle();
      check("pc_stallf", 32'(bus.StallF), 1);
      check("pc_flushd", 32'(bus.FlushD), 1);
      tick();
    end
    bus.PCSrcW = 1'b1;
    settle();
    check("pc_srcw_fd", 32'(bus.FlushD), 1);
    tick();
    bus.PCSrcW = 1'b0;
    settle();
    check("pc_idle", 32'(ctl()), 0);

    // PC write squashed by branch
    bus.PCWrD   = 1'b1;
    bus.BranchE = 1'b1;
    tick();
    clr();
    settle();
    check("pc_br", 32'(ctl()), 0);

    // PC write held by load-use stall
    bus.PCWrD     = 1'b1;
    bus.WA_E      = 4'd4;
    bus.MemtoRegE = 1'b1;
    bus.RegWrE    = 1'b1;
    bus.RA_D      = {4'd0, 4'd0, 4'd4};
    bus.UseD      = 3'b001;
    tick();
    clr();
    settle();
    check("pc_ldr", 32'(ctl()), 0);

    // reset mid-multicycle and mid-PCWAIT
    bus.PCWrD = 1'b1;
    tick();
    bus.PCWrD     = 1'b0;
    bus.MulStartE = 1'b1;
    tick();
    bus.MulStartE = 1'b0;
    settle();
    check("pre_busy", 32'(bus.Busy), 1);
    check("pre_stallf", 32'(bus.StallF), 1);
    check("pre_cnt", 32'(u_dut.cnt_q), 2);
    reset         = 1'b1;
    bus.MulStartE = 1'b1;
    bus.PCWrD     = 1'b1;
    tick();
    reset = 1'b0;
    clr();
    settle();
    check("rr_busy", 32'(bus.Busy), 0);
    check("rr_stallf", 32'(bus.StallF), 0);
    check("rr_flushd", 32'(bus.FlushD), 0);
    check("rr_cnt", 32'(u_dut.cnt_q), 0);

    // illegal combination: outputs still follow
    bus.BranchE   = 1'b1;
    bus.MulStartE = 1'b1;
    settle();
    check("ill_ctl", 32'(ctl()), 32'b1111011);
    tick();
    clr();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("ill_rst", 32'(ctl()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
